// File: rtl/dkong3_audio_pkg.sv
// dkong3_audio_pkg
//   Shared widths, saturation limits and clamp helpers for the DK3 audio
//   decimator.
//   SAMPLE_W  : width of mixer samples and of the decimated output
//   DC_W      : width of the DC-blocker state register
//   sat16()   : clamp an 18-bit signed value to 16 bits
//   sat18()   : clamp a 20-bit signed value to 18 bits
package dkong3_audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DC_W     = 18;

  localparam logic signed [15:0] SAT_MAX16 = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN16 = 16'sh8000;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return SAT_MAX16;
    else if (v < -18'sd32768)
      return SAT_MIN16;
    else
      return v[15:0];
  endfunction

  function automatic logic signed [17:0] sat18(input logic signed [19:0] v);
    if (v > 20'sd131071)
      return 18'sh1FFFF;
    else if (v < -20'sd131072)
      return 18'sh20000;
    else
      return v[17:0];
  endfunction

endpackage

// File: rtl/dkong3_audio_decim_if.sv
// dkong3_audio_decim_if
//   Sample input strobe/data plus the valid/ready output stream of the
//   decimator.
//   I_SAMPLE_CE  : one-cycle strobe, I_SAMPLE valid
//   I_SAMPLE     : signed 16-bit mixer sample
//   I_READY      : consumer accepts O_DATA
//   O_VALID      : output FIFO non-empty
//   O_DATA       : signed decimated sample at FIFO head
//   O_OVERFLOW   : sticky, a result was dropped on a full FIFO
//   master : driver side (mixer + audio-out framework)
//   slave  : decimator side
interface dkong3_audio_decim_if;
  import dkong3_audio_pkg::*;

  logic                I_SAMPLE_CE;
  logic [SAMPLE_W-1:0] I_SAMPLE;
  logic                I_READY;
  logic                O_VALID;
  logic [SAMPLE_W-1:0] O_DATA;
  logic                O_OVERFLOW;

  modport master (
    output I_SAMPLE_CE, I_SAMPLE, I_READY,
    input  O_VALID, O_DATA, O_OVERFLOW
  );

  modport slave (
    input  I_SAMPLE_CE, I_SAMPLE, I_READY,
    output O_VALID, O_DATA, O_OVERFLOW
  );

endinterface

// File: rtl/dkong3_audio_fifo.sv
// dkong3_audio_fifo
//   Small synchronous FIFO. The head entry is presented from the storage
//   registers; a push on a full FIFO is accepted only when a pop frees a
//   slot in the same cycle, otherwise it is ignored (the caller flags it).
//   clk, rst : clock, synchronous active-high reset (clears storage too)
//   push     : write wr_data           full  : DEPTH entries held
//   pop      : advance head            empty : no entries held
//   rd_data  : head entry              count : entries held (0..DEPTH)
module dkong3_audio_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     pop,
  output logic                     empty,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dkong3_audio_decim.sv
// dkong3_audio_decim
//   Box-filter and decimate the DK3 mixer output by 2^DECIM_LOG2, optionally
//   remove DC, saturate to 16 bits and queue results for the audio-out
//   framework.
//   I_CLK_24M : system clock
//   I_RESET   : synchronous active-high reset
//   bus       : sample strobe/data in, valid/ready stream out, sticky overflow
//   Pipeline: S1 = block average, S2 = DC blocker (or plain register),
//   S3 = saturate + FIFO write. A block-ending CE in cycle t shows O_VALID
//   in cycle t+3 when the FIFO was empty. The pipeline never stalls.
//   Optional feature: define DKONG3_AUDIO_DCBLOCK_EN to build the S2 DC
//   blocker; otherwise S2 just sign-extends the average.
module dkong3_audio_decim
  import dkong3_audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 5,
  parameter int DC_SHIFT   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  I_CLK_24M,
  input  logic                  I_RESET,
  dkong3_audio_decim_if.slave   bus
);

  localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

  if (DECIM_LOG2 < 1 || DECIM_LOG2 > 8 || DC_SHIFT < 4 || DC_SHIFT > 14 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("dkong3_audio_decim: illegal parameter value");
  end

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    sum;
  logic [DECIM_LOG2-1:0]      cnt;
  logic                       s1_valid;
  logic signed [SAMPLE_W-1:0] s1_avg;
  logic                       s2_valid;
  logic signed [DC_W-1:0]     s2_y;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [SAMPLE_W-1:0]        fifo_head;
  logic                       overflow;

  assign sum = acc + ACC_W'($signed(bus.I_SAMPLE));

  // S1: accumulate; on the last CE of a block the average includes that
  // CE's sample and the accumulator restarts from zero.
  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      acc      <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_avg   <= '0;
    end else begin
      s1_valid <= 1'b0;
      if (bus.I_SAMPLE_CE) begin
        cnt <= cnt + DECIM_LOG2'(1);
        if (cnt == '1) begin
          s1_valid <= 1'b1;
          s1_avg   <= 16'(sum >>> DECIM_LOG2);
          acc      <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

`ifdef DKONG3_AUDIO_DCBLOCK_EN
  // S2: one-pole DC blocker. The y register is both the filter state and
  // the stage output, so latency matches the plain-register build.
  logic signed [SAMPLE_W-1:0] x_prev;
  logic signed [19:0]         dc_w;

  always_comb begin
    dc_w = 20'(s1_avg) - 20'(x_prev) + 20'(s2_y) - 20'(s2_y >>> DC_SHIFT);
  end

  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      x_prev   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y   <= sat18(dc_w);
        x_prev <= s1_avg;
      end
    end
  end
`else
  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_y <= DC_W'(s1_avg);
    end
  end
`endif

  // S3: saturate straight into the FIFO write port.
  dkong3_audio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (I_CLK_24M),
    .rst     (I_RESET),
    .push    (s2_valid),
    .wr_data (sat16(s2_y)),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .empty   (fifo_empty),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  assign fifo_pop = bus.I_READY & ~fifo_empty;

  always_ff @(posedge I_CLK_24M) begin
    if (I_RESET)
      overflow <= 1'b0;
    else if (s2_valid && fifo_full && !fifo_pop)
      overflow <= 1'b1;
  end

  assign bus.O_VALID    = (fifo_count != '0);
  assign bus.O_DATA     = fifo_head;
  assign bus.O_OVERFLOW = overflow;

endmodule

// File: tb/tb_dkong3_audio_decim.sv
// tb_dkong3_audio_decim
//   Randomised and directed stimulus against a block-average / FIFO
//   reference model kept in plain integer arithmetic. Outputs are compared
//   on every falling edge.
module tb_dkong3_audio_decim;

  localparam int N_BLK    = 32;
  localparam int DEPTH    = 4;
  localparam int DC_SHIFT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dkong3_audio_decim_if bus();

  dkong3_audio_decim dut (
    .I_CLK_24M (clk),
    .I_RESET   (rst),
    .bus       (bus)
  );

  typedef struct {
    int val;
    int due;
  } pend_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    q[$];
  pend_t pend[$];
  int    hist[$];
  int    blk_sum = 0;
  int    blk_n   = 0;
  int    cyc     = 0;
  int    m_ovf   = 0;
  int    x_prev  = 0;
  int    y_dc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) r = r - 1;
    return r;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int model_out(input int avg);
`ifdef DKONG3_AUDIO_DCBLOCK_EN
    int w;
    w      = avg - x_prev + y_dc - floor_div(y_dc, 1 << DC_SHIFT);
    y_dc   = clamp(w, -131072, 131071);
    x_prev = avg;
    return clamp(y_dc, -32768, 32767);
`else
    return avg;
`endif
  endfunction

  function automatic int last_hist();
    return (hist.size() > 0) ? hist[hist.size()-1] : -1;
  endfunction

  // One clock edge's worth of reference behaviour.
  task automatic model_edge(input bit ce, input logic [15:0] smp, input bit rdy, input bit due);
    pend_t p;
    int    avg;
    if (q.size() > 0 && rdy) hist.push_back(q.pop_front());
    if (due) begin
      p = pend.pop_front();
      if (q.size() < DEPTH) q.push_back(p.val);
      else m_ovf = 1;
    end
    if (ce) begin
      blk_sum += int'($signed(smp));
      blk_n++;
      if (blk_n == N_BLK) begin
        avg = floor_div(blk_sum, N_BLK);
        pend.push_back('{val: model_out(avg) & 'hFFFF, due: cyc + 2});
        blk_sum = 0;
        blk_n   = 0;
      end
    end
  endtask

  // rmode: 0 never ready, 1 always, 2 random, 3 only when a push lands, 4 rarely
  task automatic tick(input bit ce, input logic [15:0] smp, input int rmode);
    bit rdy;
    bit due;
    @(negedge clk);
    check_eq("valid", 32'(bus.O_VALID), 32'(q.size() > 0));
    check_eq("overflow", 32'(bus.O_OVERFLOW), 32'(m_ovf));
    if (q.size() > 0) check_eq("data", 32'(bus.O_DATA), 32'(q[0]));
    due = (pend.size() > 0) && (pend[0].due == cyc);
    case (rmode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      3:       rdy = due;
      default: rdy = ($urandom_range(0, 7) == 0);
    endcase
    bus.I_SAMPLE_CE = ce;
    bus.I_SAMPLE    = smp;
    bus.I_READY     = rdy;
    model_edge(ce, smp, rdy, due);
    cyc++;
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0, rmode);
  endtask

  // smode: 0 constant base, 1 alternating base/0, 2 random
  task automatic run_ces(input int n, input int smode, input logic [15:0] base,
                         input int rmode, input int gap);
    logic [15:0] s;
    for (int i = 0; i < n; i++) begin
      case (smode)
        0:       s = base;
        1:       s = (i % 2 == 0) ? base : 16'h0;
        default: s = 16'($urandom);
      endcase
      tick(1'b1, s, rmode);
      if (gap > 0) idle($urandom_range(0, gap), rmode);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    bus.I_SAMPLE_CE = 1'b0;
    bus.I_SAMPLE    = 16'h0;
    bus.I_READY     = 1'b0;
    q.delete();
    pend.delete();
    hist.delete();
    blk_sum = 0;
    blk_n   = 0;
    m_ovf   = 0;
    x_prev  = 0;
    y_dc    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(bus.O_VALID), 32'd0);
    check_eq("rst_data", 32'(bus.O_DATA), 32'd0);
    check_eq("rst_overflow", 32'(bus.O_OVERFLOW), 32'd0);
    rst = 1'b0;
    cyc += 3;
  endtask

  initial begin
    #5ms;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int  lat;
    bit  seen;
    bus.I_SAMPLE_CE = 1'b0;
    bus.I_SAMPLE    = 16'h0;
    bus.I_READY     = 1'b0;

    // Constant 0x1000 and first-output latency.
    do_reset();
    run_ces(N_BLK, 0, 16'h1000, 0, 0);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick(1'b0, 16'h0, 0);
      lat++;
      seen = bus.O_VALID;
    end
    check_eq("latency", 32'(lat), 32'd3);
    idle(2, 1);
    check_eq("c1000_first", 32'(last_hist()), 32'h1000);
    run_ces(N_BLK, 0, 16'h1000, 1, 2);
    idle(6, 1);
    check_eq("c1000_count", 32'(hist.size()), 32'd2);
`ifndef DKONG3_AUDIO_DCBLOCK_EN
    check_eq("c1000_second", 32'(last_hist()), 32'h1000);
    run_ces(N_BLK, 1, 16'h0001, 1, 0);
    idle(6, 1);
    check_eq("alt_floor", 32'(last_hist()), 32'h0000);
    run_ces(N_BLK, 0, 16'hFFFF, 1, 1);
    idle(6, 1);
    check_eq("neg_one", 32'(last_hist()), 32'hFFFF);
`endif

    // Backpressure: five results into a four-entry FIFO.
    do_reset();
    for (int v = 1; v <= 5; v++) run_ces(N_BLK, 0, 16'(v), 0, 0);
    idle(4, 0);
    check_eq("ovf_set", 32'(bus.O_OVERFLOW), 32'd1);
    idle(8, 1);
    check_eq("drain_n", 32'(hist.size()), 32'd4);
    for (int i = 0; i < 4 && i < hist.size(); i++)
      check_eq("drain_order", 32'(hist[i]), 32'(i + 1));

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    for (int v = 1; v <= 4; v++) run_ces(N_BLK, 0, 16'(v), 0, 0);
    idle(4, 0);
    run_ces(N_BLK, 0, 16'd5, 3, 0);
    idle(4, 3);
    check_eq("fullpp_ovf", 32'(bus.O_OVERFLOW), 32'd0);
    check_eq("fullpp_pop1", 32'(hist.size()), 32'd1);
    idle(8, 1);
    check_eq("fullpp_total", 32'(hist.size()), 32'd5);
    check_eq("fullpp_last", 32'(last_hist()), 32'd5);

    // Single entry with push and pop in the same cycle.
    do_reset();
    run_ces(N_BLK, 0, 16'd7, 3, 0);
    idle(4, 3);
    run_ces(N_BLK, 0, 16'd9, 3, 0);
    idle(4, 3);
    check_eq("one_pp_popped", 32'(last_hist()), 32'd7);
    check_eq("one_pp_valid", 32'(bus.O_VALID), 32'd1);
    check_eq("one_pp_head", 32'(bus.O_DATA), 32'd9);

    // Reset in the middle of a block discards the partial sum.
    do_reset();
    run_ces(20, 0, 16'h7FFF, 1, 0);
    do_reset();
    run_ces(N_BLK - 1, 0, 16'h0100, 1, 0);
    idle(5, 1);
    check_eq("rst_mid_no_out", 32'(hist.size()), 32'd0);
    run_ces(1, 0, 16'h0100, 1, 0);
    idle(5, 1);
    check_eq("rst_mid_out", 32'(last_hist()), 32'h0100);
    check_eq("rst_mid_ovf", 32'(bus.O_OVERFLOW), 32'd0);

`ifdef DKONG3_AUDIO_DCBLOCK_EN
    // Step response decays toward zero without going negative.
    do_reset();
    run_ces(2 * N_BLK, 0, 16'h0, 1, 0);
    hist.delete();
    run_ces(6 * N_BLK, 0, 16'h4000, 1, 0);
    idle(6, 1);
    check_eq("step_first", 32'(hist.size() > 0 ? hist[0] : -1), 32'h4000);
    for (int i = 1; i < hist.size(); i++)
      check_eq("step_decay", 32'(hist[i] < hist[i-1] && hist[i] < 'h8000), 32'd1);

    // Full-scale square wave clamps at the rails.
    do_reset();
    for (int b = 0; b < 6; b++)
      run_ces(N_BLK, 0, (b % 2 == 0) ? 16'h7FFF : 16'h8000, 1, 0);
    idle(6, 1);
    for (int i = 0; i < hist.size(); i++)
      check_eq("square_clamp", 32'(hist[i]), (i % 2 == 0) ? 32'h7FFF : 32'h8000);
`endif

    // Random samples, CE density and backpressure.
    do_reset();
    for (int i = 0; i < 2500; i++)
      tick(1'($urandom_range(0, 1)), 16'($urandom), 2);
    for (int i = 0; i < 1500; i++)
      tick(1'b1, 16'($urandom), 4);
    idle(10, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
